// File: rtl/button_conditioner.sv
// Five-button synchronizer, debouncer and press-pulse generator.
// Define BUTTON_AUTOREPEAT_EN to compile in auto-repeat for L/U/D/R.
module button_conditioner #(
  parameter int unsigned DB_CYCLES    = 488,
  parameter int unsigned REPEAT_DELAY = 12207,
  parameter int unsigned REPEAT_RATE  = 3662
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       BtnL,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnR,
  input  logic       BtnC,
  output logic       BtnL_pulse,
  output logic       BtnU_pulse,
  output logic       BtnD_pulse,
  output logic       BtnR_pulse,
  output logic       BtnC_pulse,
  output logic [4:0] btn_level
);

  localparam int unsigned NB  = 5;
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("button_conditioner: cycle parameters must be at least 1");
  end

  logic [NB-1:0]  raw_c;
  logic [NB-1:0]  meta;
  logic [NB-1:0]  sync;
  logic [NB-1:0]  level;
  logic [NB-1:0]  level_q;
  logic [NB-1:0]  pulse;
  logic [NB-1:0]  press_c;
  logic [NB-1:0]  pulse_c;
  logic [DBW-1:0] db_cnt [NB];

  assign raw_c   = {BtnC, BtnR, BtnD, BtnU, BtnL};
  assign press_c = level & ~level_q;

  // Synchronizer, debounce counters, edge register and output pulse register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta    <= '0;
      sync    <= '0;
      level   <= '0;
      level_q <= '0;
      pulse   <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      meta    <= raw_c;
      sync    <= meta;
      level_q <= level;
      pulse   <= pulse_c;
      for (int i = 0; i < NB; i++) begin
        if (sync[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          level[i]  <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned NR   = 4;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_MAX = RW'(REPEAT_RATE - 1);

  // A one-cycle repeat period would leave no low cycle between pulses
  if (REPEAT_RATE < 2) begin : g_bad_rate
    $error("button_conditioner: REPEAT_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} rep_state_t;

  rep_state_t      rep_state     [NR];
  rep_state_t      rep_state_nxt [NR];
  logic [RW-1:0]   rep_cnt       [NR];
  logic [RW-1:0]   rep_cnt_nxt   [NR];
  logic [NR-1:0]   rep_fire_c;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NR; i++) begin
        rep_state[i] <= IDLE;
        rep_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        rep_state[i] <= rep_state_nxt[i];
        rep_cnt[i]   <= rep_cnt_nxt[i];
      end
    end
  end

  // Per-button repeat sequencing; a falling level always returns to IDLE
  always_comb begin
    rep_fire_c = '0;
    for (int i = 0; i < NR; i++) begin
      rep_state_nxt[i] = rep_state[i];
      rep_cnt_nxt[i]   = rep_cnt[i];
      case (rep_state[i])
        IDLE: begin
          if (press_c[i]) begin
            rep_state_nxt[i] = HOLD_DELAY;
            rep_cnt_nxt[i]   = '0;
          end
        end
        HOLD_DELAY: begin
          if (rep_cnt[i] == RD_MAX) begin
            rep_fire_c[i]    = 1'b1;
            rep_state_nxt[i] = HOLD_REPEAT;
            rep_cnt_nxt[i]   = '0;
          end else if (rep_cnt[i] != '1) begin
            rep_cnt_nxt[i] = rep_cnt[i] + RW'(1);
          end
        end
        HOLD_REPEAT: begin
          if (rep_cnt[i] == RR_MAX) begin
            rep_fire_c[i]  = 1'b1;
            rep_cnt_nxt[i] = '0;
          end else if (rep_cnt[i] != '1) begin
            rep_cnt_nxt[i] = rep_cnt[i] + RW'(1);
          end
        end
        default: begin
          rep_state_nxt[i] = IDLE;
          rep_cnt_nxt[i]   = '0;
        end
      endcase
      if (!level[i]) begin
        rep_state_nxt[i] = IDLE;
        rep_cnt_nxt[i]   = '0;
        rep_fire_c[i]    = 1'b0;
      end
    end
  end

  assign pulse_c = press_c | {1'b0, rep_fire_c};
`else
  assign pulse_c = press_c;
`endif

  assign BtnL_pulse = pulse[0];
  assign BtnU_pulse = pulse[1];
  assign BtnD_pulse = pulse[2];
  assign BtnR_pulse = pulse[3];
  assign BtnC_pulse = pulse[4];
  assign btn_level  = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce/repeat settings.
module tb_button_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       BtnL = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnR = 1'b0, BtnC = 1'b0;
  logic       BtnL_pulse, BtnU_pulse, BtnD_pulse, BtnR_pulse, BtnC_pulse;
  logic [4:0] btn_level;

  button_conditioner #(
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .BtnL      (BtnL),
    .BtnU      (BtnU),
    .BtnD      (BtnD),
    .BtnR      (BtnR),
    .BtnC      (BtnC),
    .BtnL_pulse(BtnL_pulse),
    .BtnU_pulse(BtnU_pulse),
    .BtnD_pulse(BtnD_pulse),
    .BtnR_pulse(BtnR_pulse),
    .BtnC_pulse(BtnC_pulse),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] pulse;
    logic [4:0] level;
  } exp_t;

  typedef struct {
    string      name;
    logic [4:0] mask;
    int         hold;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [4:0] act_pulse();
    return {BtnC_pulse, BtnR_pulse, BtnD_pulse, BtnU_pulse, BtnL_pulse};
  endfunction

  task automatic set_raw(input logic [4:0] v);
    {BtnC, BtnR, BtnD, BtnU, BtnL} = v;
  endtask

  // Raw high for sampling edges 1..hold: level rises at DB+2, falls at hold+DB+2
  function automatic exp_t expect_at(input logic [4:0] mask, input int hold, input int e);
    exp_t r;
    int   p;
    p = DB + 3;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (mask[i]) begin
        r.level[i] = (e >= DB + 2) && (e < hold + DB + 2);
        if (e == p) r.pulse[i] = 1'b1;
        if (AR && i != 4 && e >= p + RD && ((e - p - RD) % RR) == 0 && e <= hold + DB + 2)
          r.pulse[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check5(input string name, input int e, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %b, required %b", name, e, act, exp);
    end
  endtask

  task automatic step_and_compare(input string name, input int e);
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s edge %0d: scoreboard empty, got 0 required 1 entry", name, e);
    end else begin
      x = sb.pop_front();
      check5({name, "_pulse"}, e, act_pulse(), x.pulse);
      check5({name, "_level"}, e, btn_level, x.level);
    end
  endtask

  task automatic run_press(input string name, input logic [4:0] mask, input int hold, input int total);
    set_raw(mask);
    for (int e = 1; e <= total; e++) begin
      sb.push_back(expect_at(mask, hold, e));
      step_and_compare(name, e);
      if (e == hold) set_raw(5'b0);
    end
  endtask

  initial begin
    tbl.push_back('{"clean_u",   5'b00010,  8});
    tbl.push_back('{"simul_lc",  5'b10001, 10});
    tbl.push_back('{"hold_r",    5'b01000, 40});
    tbl.push_back('{"hold_c",    5'b10000, 40});
    tbl.push_back('{"hold_d",    5'b00100, 40});
    tbl.push_back('{"all_five",  5'b11111, 12});

    // Outputs stay low in reset even with a button held
    set_raw(5'b00010);
    repeat (4) @(posedge clk);
    #1;
    check5("in_reset_pulse", 0, act_pulse(), 5'b0);
    check5("in_reset_level", 0, btn_level, 5'b0);
    set_raw(5'b0);
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    run_press("idle", 5'b0, 0, 6);

    for (int t = 0; t < tbl.size(); t++)
      run_press(tbl[t].name, tbl[t].mask, tbl[t].hold, tbl[t].hold + int'(DB) + 8);

    // Bounce: L high 3 samples, low 1, high 3, then released
    begin
      logic b;
      set_raw(5'b00001);
      for (int e = 1; e <= 20; e++) begin
        sb.push_back('0);
        step_and_compare("bounce_l", e);
        b = ((e + 1) <= 3) || ((e + 1) >= 5 && (e + 1) <= 7);
        set_raw({4'b0, b});
      end
    end

    // Reset during HOLD_REPEAT, button still held afterwards
    set_raw(5'b01000);
    for (int e = 1; e <= 20; e++) begin
      sb.push_back(expect_at(5'b01000, 1000, e));
      step_and_compare("pre_reset_r", e);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    check5("reset_async_pulse", 0, act_pulse(), 5'b0);
    check5("reset_async_level", 0, btn_level, 5'b0);
    repeat (3) @(posedge clk);
    #1;
    check5("reset_hold_pulse", 0, act_pulse(), 5'b0);
    check5("reset_hold_level", 0, btn_level, 5'b0);
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    run_press("post_reset_r", 5'b01000, 30, 30 + int'(DB) + 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
